// File: rtl/multi_mod_pkg.sv
// ============================================================================
// multi_mod_pkg : shared defaults and helpers for the multi-rate tick generator
// Rev 1.0
// ============================================================================
`default_nettype none

package multi_mod_pkg;

  localparam int N_CH_DEF       = 4;
  localparam int DW_DEF         = 8;
  localparam int MAX_CYCLES_DEF = 100;

  localparam int CW = $clog2(MAX_CYCLES_DEF);
  localparam int SW = (N_CH_DEF > 1) ? $clog2(N_CH_DEF) : 1;

  typedef logic [DW_DEF-1:0] div_t;

  // Compared one bit wider than the counter so cnt+1 cannot alias to zero
  function automatic logic is_match(input logic [31:0] cnt, input logic [31:0] div);
    logic [32:0] inc;
    inc = {1'b0, cnt} + 33'd1;
    return inc == {1'b0, div};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_chan.sv
// ============================================================================
// mod_chan : one modulo channel -- divisor, phase counter and registered tick
// Rev 1.0
// ============================================================================
`default_nettype none

module mod_chan
  import multi_mod_pkg::*;
#(
  parameter int          DW       = DW_DEF,
  parameter logic [DW-1:0] DIV_INIT = '0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          step,
  input  logic          restart,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  output logic          hit,
  output logic          hit_nxt,
  output logic          enabled
);

  logic [DW-1:0] div, div_d;
  logic [DW-1:0] cnt, cnt_d;
  logic          hit_d;
  logic          live;
  logic          match;

  assign live  = (div != '0);
  assign match = is_match(32'(cnt), 32'(div));

  // A divisor write wins over every other update for this channel
  always_comb begin
    div_d = div;
    cnt_d = cnt;
    hit_d = 1'b0;
    if (wr) begin
      div_d = wdata;
      cnt_d = '0;
    end else if (restart) begin
      cnt_d = '0;
      hit_d = live;
    end else if (step && live) begin
      hit_d = match;
      cnt_d = match ? '0 : cnt + 1'b1;
    end else if (step) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div <= DIV_INIT;
      cnt <= '0;
      hit <= (DIV_INIT != '0);
    end else begin
      div <= div_d;
      cnt <= cnt_d;
      hit <= hit_d;
    end
  end

  // Next-state view lets the top register its reductions alongside hit
  assign hit_nxt = hit_d;
  assign enabled = (div_d != '0);

endmodule

`default_nettype wire

// File: rtl/multi_mod_ticker.sv
// ============================================================================
// multi_mod_ticker : N_CH programmable modulo tick generator with run control
// Rev 1.0
// ============================================================================
`default_nettype none

module multi_mod_ticker
  import multi_mod_pkg::*;
#(
  parameter int                 N_CH       = N_CH_DEF,
  parameter int                 DW         = DW_DEF,
  parameter int                 MAX_CYCLES = MAX_CYCLES_DEF,
  // Channel 0 occupies the least significant DW bits
  parameter logic [N_CH*DW-1:0] DIV_INIT   = {8'd15, 8'd7, 8'd5, 8'd3}
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic                                     en,
  input  logic                                     clr,
  input  logic                                     div_we,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] div_sel,
  input  logic [DW-1:0]                            div_wdata,
  output logic [N_CH-1:0]                          hit,
  output logic                                     all_hit,
  output logic                                     any_hit,
  output logic [$clog2(MAX_CYCLES)-1:0]            cycle_cnt,
  output logic                                     done
);

  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(MAX_CYCLES);

  function automatic logic [N_CH-1:0] init_mask();
    logic [N_CH-1:0] m;
    for (int i = 0; i < N_CH; i++) m[i] = (DIV_INIT[i*DW +: DW] != '0);
    return m;
  endfunction

  localparam logic [N_CH-1:0] INIT_MASK = init_mask();

  logic             wrap;
  logic             restart;
  logic [N_CH-1:0]  hit_nxt;
  logic [N_CH-1:0]  en_nxt;
  logic [CNT_W-1:0] cycle_d;
  logic             done_d;
  logic             all_d;
  logic             any_d;

  assign wrap    = en && (cycle_cnt == CNT_W'(MAX_CYCLES - 1));
  assign restart = clr || wrap;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    mod_chan #(
      .DW       (DW),
      .DIV_INIT (DIV_INIT[i*DW +: DW])
    ) u_chan (
      .clk     (clk),
      .resetn  (resetn),
      .step    (en),
      .restart (restart),
      .wr      (div_we && (div_sel == SEL_W'(i))),
      .wdata   (div_wdata),
      .hit     (hit[i]),
      .hit_nxt (hit_nxt[i]),
      .enabled (en_nxt[i])
    );
  end

  always_comb begin
    cycle_d = cycle_cnt;
    if (restart)  cycle_d = '0;
    else if (en)  cycle_d = cycle_cnt + 1'b1;
    done_d = wrap && !clr;
    any_d  = |hit_nxt;
    all_d  = (|en_nxt) && (&(hit_nxt | ~en_nxt));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycle_cnt <= '0;
      done      <= 1'b0;
      any_hit   <= |INIT_MASK;
      all_hit   <= |INIT_MASK;
    end else begin
      cycle_cnt <= cycle_d;
      done      <= done_d;
      any_hit   <= any_d;
      all_hit   <= all_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_mod_ticker.sv
// ============================================================================
// tb_multi_mod_ticker : scoreboard bench against an arithmetic reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multi_mod_ticker;

  localparam int N_CH = 4;
  localparam int DW   = 8;
  localparam int MAXC = 100;
  localparam int CW   = 7;
  localparam int SW   = 2;
  localparam int INIT_DIV [N_CH] = '{3, 5, 7, 15};

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            en = 1'b0;
  logic            clr = 1'b0;
  logic            div_we = 1'b0;
  logic [SW-1:0]   div_sel = '0;
  logic [DW-1:0]   div_wdata = '0;
  logic [N_CH-1:0] hit;
  logic            all_hit;
  logic            any_hit;
  logic [CW-1:0]   cycle_cnt;
  logic            done;

  always #5 clk = ~clk;

  multi_mod_ticker dut (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .clr       (clr),
    .div_we    (div_we),
    .div_sel   (div_sel),
    .div_wdata (div_wdata),
    .hit       (hit),
    .all_hit   (all_hit),
    .any_hit   (any_hit),
    .cycle_cnt (cycle_cnt),
    .done      (done)
  );

  typedef struct packed {
    logic [N_CH-1:0] hit;
    logic            all_h;
    logic            any_h;
    logic [CW-1:0]   cyc;
    logic            done;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference: phase = enabled steps since the channel last restarted
  int              m_div [N_CH];
  int              m_ph  [N_CH];
  int              m_n;
  logic [N_CH-1:0] m_hit;
  logic            m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t            e;
    logic [N_CH-1:0] mask;
    for (int i = 0; i < N_CH; i++) mask[i] = (m_div[i] != 0);
    e.hit   = m_hit;
    e.all_h = (mask != '0) && ((m_hit & mask) == mask);
    e.any_h = (m_hit != '0);
    e.cyc   = CW'(m_n);
    e.done  = m_done;
    return e;
  endfunction

  task automatic model_reset();
    m_n    = 0;
    m_done = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      m_div[i] = INIT_DIV[i];
      m_ph[i]  = 0;
      m_hit[i] = (INIT_DIV[i] != 0);
    end
  endtask

  task automatic model_step(input logic e, input logic c, input logic w, input int s, input int d);
    if (c || (e && m_n == MAXC - 1)) begin
      m_done = !c;
      m_n    = 0;
      for (int i = 0; i < N_CH; i++) begin
        m_ph[i]  = 0;
        m_hit[i] = (m_div[i] != 0);
      end
    end else if (e) begin
      m_done = 1'b0;
      m_n++;
      for (int i = 0; i < N_CH; i++) begin
        if (m_div[i] != 0) begin
          m_ph[i]++;
          m_hit[i] = ((m_ph[i] % m_div[i]) == 0);
        end else begin
          m_ph[i]  = 0;
          m_hit[i] = 1'b0;
        end
      end
    end else begin
      m_done = 1'b0;
      m_hit  = '0;
    end
    if (w && s < N_CH) begin
      m_div[s] = d;
      m_ph[s]  = 0;
      m_hit[s] = 1'b0;
    end
  endtask

  task automatic drive(input logic e, input logic c, input logic w, input int s, input int d);
    @(negedge clk);
    en        = e;
    clr       = c;
    div_we    = w;
    div_sel   = SW'(s);
    div_wdata = DW'(d);
    model_step(e, c, w, s, d);
    q.push_back(model_out());
  endtask

  // Reset is pulsed entirely inside the low clock phase, then one idle edge is queued
  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    en     = 1'b0;
    clr    = 1'b0;
    div_we = 1'b0;
    resetn = 1'b0;
    #1;
    model_reset();
    e = model_out();
    chk("rst_hit",   32'(hit),       32'(e.hit));
    chk("rst_all",   32'(all_hit),   32'(e.all_h));
    chk("rst_any",   32'(any_hit),   32'(e.any_h));
    chk("rst_cycle", 32'(cycle_cnt), 32'(e.cyc));
    chk("rst_done",  32'(done),      32'(e.done));
    #1 resetn = 1'b1;
    model_step(1'b0, 1'b0, 1'b0, 0, 0);
    q.push_back(model_out());
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("hit",       32'(hit),       32'(e.hit));
        chk("all_hit",   32'(all_hit),   32'(e.all_h));
        chk("any_hit",   32'(any_hit),   32'(e.any_h));
        chk("cycle_cnt", 32'(cycle_cnt), 32'(e.cyc));
        chk("done",      32'(done),      32'(e.done));
      end
    end
  end

  initial begin : stimulus
    int guard;
    do_reset();
    repeat (15) drive(1'b1, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 30; i++) drive((i % 3) != 1, 1'b0, 1'b0, 0, 0);

    do_reset();
    repeat (210) drive(1'b1, 1'b0, 1'b0, 0, 0);

    do_reset();
    repeat (3) drive(1'b1, 1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1'b1, 1, 2);
    repeat (8) drive(1'b1, 1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1'b1, 1, 0);
    repeat (8) drive(1'b1, 1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b1, 1'b1, 2, 4);

    guard = 0;
    while (m_n != MAXC - 1 && guard < 2 * MAXC) begin
      drive(1'b1, 1'b0, 1'b0, 0, 0);
      guard++;
    end
    drive(1'b1, 1'b1, 1'b1, 0, 6);
    repeat (5) drive(1'b1, 1'b0, 1'b0, 0, 0);

    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 49) == 0,
            $urandom_range(0, 19) == 0,
            int'($urandom_range(0, N_CH - 1)),
            ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 9)));
    end

    repeat (20) drive(1'b1, 1'b0, 1'b0, 0, 0);
    do_reset();
    repeat (4) drive(1'b1, 1'b0, 1'b0, 0, 0);

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
